// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, IF/ID pipeline register,
// stall hold buffer and delayed branch redirect (delay-slot semantics).
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        jump_enable,
    input  logic [31:0] jump_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_addr_q, redir_addr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        deliver;
    logic        jump_take;
    logic [31:0] word;
    logic [31:0] next_pc;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        redir_pend_d = redir_pend_q;
        redir_addr_d = redir_addr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;

        deliver   = ((state_q == S_WAIT) && imem_rvalid && !stall) ||
                    ((state_q == S_HOLD) && !stall);
        jump_take = jump_enable && !stall;
        word      = (state_q == S_HOLD) ? hold_q : imem_rdata;
        // A jump resolved this cycle wins over an older pending redirect
        next_pc   = jump_take    ? jump_addr :
                    redir_pend_q ? redir_addr_q : pc_q + 32'd4;

        case (state_q)
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (stall) begin
                        state_d = S_HOLD;
                        hold_d  = imem_rdata;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_HOLD: if (!stall) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase

        if (deliver) begin
            pc_d         = next_pc;
            redir_pend_d = 1'b0;
            ifid_pc_d    = pc_q;
            ifid_instr_d = word;
            ifid_valid_d = 1'b1;
        end else begin
            if (jump_take) begin
                redir_pend_d = 1'b1;
                redir_addr_d = jump_addr;
            end
            // Not stalled and nothing delivered: decode sees a bubble
            if (!stall) ifid_valid_d = 1'b0;
        end

        if (flush) begin
            ifid_pc_d    = '0;
            ifid_instr_d = '0;
            ifid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            hold_q       <= '0;
            redir_pend_q <= 1'b0;
            redir_addr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_q       <= hold_d;
            redir_pend_q <= redir_pend_d;
            redir_addr_q <= redir_addr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem_req          = (state_q == S_REQ) && !rst;
    assign imem_addr         = pc_q;
    assign if_id_pc          = ifid_pc_q;
    assign if_id_instruction = ifid_instr_q;
    assign if_id_valid       = ifid_valid_q;

endmodule
